// File: rtl/netlist_bist_ctrl_if.sv
// Start/done handshake toward the test top plus the stimulus/response pair toward the netlist.
// master = test top side (drives start/abort and the netlist response), slave = the BIST controller.
interface netlist_bist_ctrl_if;
    logic        start;
    logic        abort;
    logic [5:0]  vec_out;
    logic [2:0]  resp_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    modport master (
        output start, abort, resp_in,
        input  vec_out, busy, done, pass, signature
    );

    modport slave (
        input  start, abort, resp_in,
        output vec_out, busy, done, pass, signature
    );
endinterface

// File: rtl/netlist_bist_ctrl.sv
// BIST sequencer: walks all 64 netlist input vectors, holding each SETTLE+1 cycles, into a 16-bit MISR.
// Run takes 64*(SETTLE+1) cycles from start; level done/pass until the next start, abort only honoured in RUN.
module netlist_bist_ctrl #(
    parameter int unsigned SETTLE = 0,
    parameter logic [15:0] SEED   = 16'hFFFF,
    parameter logic [15:0] GOLDEN = 16'h0000,
    parameter logic [15:0] POLY   = 16'h1021
) (
    input  logic               clk,
    input  logic               rst,
    netlist_bist_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state, state_nxt;
    logic [5:0]  vec, vec_nxt;
    logic [3:0]  wait_cnt, wait_nxt;
    logic [15:0] sig, sig_nxt;
    logic [15:0] misr;
    logic        busy_r, done_r;

    // Shift-out bit is dropped; the response folds into the low three bits.
    assign misr = {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ {13'b0, bus.resp_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vec      <= 6'd0;
            wait_cnt <= 4'd0;
            sig      <= SEED;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            wait_cnt <= wait_nxt;
            sig      <= sig_nxt;
            busy_r   <= (state_nxt == RUN);
            done_r   <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        wait_nxt  = wait_cnt;
        sig_nxt   = sig;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    sig_nxt   = SEED;
                    vec_nxt   = 6'd0;
                    wait_nxt  = 4'd0;
                end
            end
            RUN: begin
                // Abort outranks a capture landing on the same edge.
                if (bus.abort) begin
                    state_nxt = IDLE;
                    sig_nxt   = SEED;
                    vec_nxt   = 6'd0;
                    wait_nxt  = 4'd0;
                end else if (wait_cnt == SETTLE_C) begin
                    sig_nxt  = misr;
                    wait_nxt = 4'd0;
                    vec_nxt  = vec + 6'd1;
                    if (vec == 6'd63) begin
                        state_nxt = DONE;
                    end
                end else begin
                    wait_nxt = wait_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.vec_out   = vec;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = done_r && (sig == GOLDEN);
    assign bus.signature = sig;
endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Directed bench for netlist_bist_ctrl: three parameterisations, scoreboarded end-of-run results.
// A: SEED=0/SETTLE=0/GOLDEN=0, B: SEED=0/GOLDEN=1 with zero response, C: SETTLE=3 with default SEED.
module tb_netlist_bist_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tie0_a = 1'b0;

    always #5 clk = ~clk;

    netlist_bist_ctrl_if ifa ();
    netlist_bist_ctrl_if ifb ();
    netlist_bist_ctrl_if ifc ();

    netlist_bist_ctrl #(.SETTLE(0), .SEED(16'h0000), .GOLDEN(16'h0000), .POLY(16'h1021))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    netlist_bist_ctrl #(.SETTLE(0), .SEED(16'h0000), .GOLDEN(16'h0001), .POLY(16'h1021))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    netlist_bist_ctrl #(.SETTLE(3), .SEED(16'hFFFF), .GOLDEN(16'h0000), .POLY(16'h1021))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    // Sample netlist: o = a&b | c, p = ~(d&e), q = ~(e&f)  (vec 0 and 1 both give 3'b011).
    function automatic logic [2:0] netlist(input logic [5:0] v);
        logic o, p, q;
        o = (v[5] & v[4]) | v[3];
        p = ~(v[2] & v[1]);
        q = ~(v[1] & v[0]);
        return {o, p, q};
    endfunction

    assign ifa.resp_in = tie0_a ? 3'b000 : netlist(ifa.vec_out);
    assign ifb.resp_in = 3'b000;

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [2:0] r);
        logic [15:0] fb;
        fb = s[15] ? 16'h1021 : 16'h0000;
        return {s[14:0], 1'b0} ^ fb ^ {13'b0, r};
    endfunction

    function automatic logic [15:0] model_sig(input logic [15:0] seed, input bit zero_resp);
        logic [15:0] s;
        logic [2:0]  r;
        s = seed;
        for (int n = 0; n < 64; n++) begin
            r = zero_resp ? 3'b000 : netlist(6'(n));
            s = misr_step(s, r);
        end
        return s;
    endfunction

    typedef struct {
        string       tag;
        logic [15:0] sig;
        logic        pass;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input int w);
        case (w)
            0: return ifa.done;
            1: return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0: return ifa.busy;
            1: return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    function automatic logic get_pass(input int w);
        case (w)
            0: return ifa.pass;
            1: return ifb.pass;
            default: return ifc.pass;
        endcase
    endfunction

    function automatic logic [5:0] get_vec(input int w);
        case (w)
            0: return ifa.vec_out;
            1: return ifb.vec_out;
            default: return ifc.vec_out;
        endcase
    endfunction

    function automatic logic [15:0] get_sig(input int w);
        case (w)
            0: return ifa.signature;
            1: return ifb.signature;
            default: return ifc.signature;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0: ifa.start = v;
            1: ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    task automatic set_abort(input int w, input logic v);
        case (w)
            0: ifa.abort = v;
            1: ifb.abort = v;
            default: ifc.abort = v;
        endcase
    endtask

    task automatic chk_reset(input string tag, input int w, input logic [15:0] seed);
        chk({tag, "_vec"},  32'(get_vec(w)),  32'h0);
        chk({tag, "_busy"}, 32'(get_busy(w)), 32'h0);
        chk({tag, "_done"}, 32'(get_done(w)), 32'h0);
        chk({tag, "_pass"}, 32'(get_pass(w)), 32'h0);
        chk({tag, "_sig"},  32'(get_sig(w)),  32'(seed));
    endtask

    // One run on instance w. Negative glitch_at/abort_at/rst_at disable that disturbance.
    task automatic run(input int w, input string tag, input logic [15:0] seed,
                       input logic [15:0] golden, input int hold,
                       input int glitch_at, input int abort_at, input int rst_at);
        exp_t e;
        exp_t got;
        int   cyc;
        int   vec_bad;
        bit   zero_resp;
        zero_resp = (w == 1) || (w == 0 && tie0_a);
        e.tag    = tag;
        e.sig    = model_sig(seed, zero_resp);
        e.pass   = (e.sig == golden);
        e.cycles = 64 * hold;
        if (abort_at < 0 && rst_at < 0) sb.push_back(e);

        set_start(w, 1'b1);
        tick();
        set_start(w, 1'b0);
        cyc = 0;
        vec_bad = 0;
        chk({tag, "_start_busy"}, 32'(get_busy(w)), 32'h1);
        chk({tag, "_start_sig"},  32'(get_sig(w)),  32'(seed));
        chk({tag, "_start_vec"},  32'(get_vec(w)),  32'h0);

        while (!get_done(w) && cyc < 64 * hold + 20) begin
            if (get_vec(w) !== 6'(cyc / hold)) vec_bad++;
            if (w == 2) begin
                // Only the capture edge may see the true response; other cycles get noise.
                if ((cyc + 1) % hold == 0) ifc.resp_in = netlist(ifc.vec_out);
                else                       ifc.resp_in = 3'($urandom);
            end
            if (cyc == glitch_at) set_start(w, 1'b1);
            if (cyc == abort_at)  set_abort(w, 1'b1);
            if (cyc == rst_at) begin
                chk({tag, "_prerst_vec"}, 32'(get_vec(w)), 32'(cyc / hold));
                #2;
                rst = 1'b1;
                #1;
                chk_reset({tag, "_async_rst"}, w, seed);
                tick();
                rst = 1'b0;
                tick();
                return;
            end
            tick();
            cyc++;
            set_start(w, 1'b0);
            set_abort(w, 1'b0);
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                chk_reset({tag, "_abort"}, w, seed);
                return;
            end
            if (w == 0 && !zero_resp && seed == 16'h0000 && cyc == 1)
                chk({tag, "_cap0_sig"}, 32'(get_sig(w)), 32'h0003);
            if (w == 0 && !zero_resp && seed == 16'h0000 && cyc == 2)
                chk({tag, "_cap1_sig"}, 32'(get_sig(w)), 32'h0005);
        end

        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h0, 32'h1);
            return;
        end
        got = sb.pop_front();
        chk({got.tag, "_done"},    32'(get_done(w)), 32'h1);
        chk({got.tag, "_cycles"},  32'(cyc),         32'(got.cycles));
        chk({got.tag, "_sig"},     32'(get_sig(w)),  32'(got.sig));
        chk({got.tag, "_pass"},    32'(get_pass(w)), 32'(got.pass));
        chk({got.tag, "_busy"},    32'(get_busy(w)), 32'h0);
        chk({got.tag, "_wrap"},    32'(get_vec(w)),  32'h0);
        chk({got.tag, "_vechold"}, 32'(vec_bad),     32'h0);

        // DONE must hold its result and ignore abort.
        set_abort(w, 1'b1);
        repeat (3) tick();
        set_abort(w, 1'b0);
        chk({got.tag, "_hold_done"}, 32'(get_done(w)), 32'h1);
        chk({got.tag, "_hold_sig"},  32'(get_sig(w)),  32'(got.sig));
        chk({got.tag, "_hold_pass"}, 32'(get_pass(w)), 32'(got.pass));
    endtask

    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0;
        ifc.start = 1'b0; ifc.abort = 1'b0;
        ifc.resp_in = 3'b000;
        rst = 1'b1;
        repeat (2) tick();
        chk_reset("rst_a", 0, 16'h0000);
        chk_reset("rst_c", 2, 16'hFFFF);
        rst = 1'b0;
        tick();
        chk_reset("idle_c", 2, 16'hFFFF);

        run(0, "a_net",         16'h0000, 16'h0000, 1, -1, -1, -1);
        run(0, "a_restart",     16'h0000, 16'h0000, 1, 20, -1, -1);
        run(0, "a_abort",       16'h0000, 16'h0000, 1, -1, 10, -1);
        run(0, "a_after_abort", 16'h0000, 16'h0000, 1, -1, -1, -1);
        tie0_a = 1'b1;
        tick();
        run(0, "a_zero",        16'h0000, 16'h0000, 1, -1, -1, -1);
        run(1, "b_zero",        16'h0000, 16'h0001, 1, -1, -1, -1);
        run(2, "c_settle3",     16'hFFFF, 16'h0000, 4, 50, -1, -1);
        run(2, "c_rst",         16'hFFFF, 16'h0000, 4, -1, -1, 160);
        run(2, "c_after_rst",   16'hFFFF, 16'h0000, 4, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
